// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: sequences the pixel timer and turns its counters into registered VGA timing outputs
// Ports: clk/n_rst (async active-low); start/stop run control; pixel_clk, counter_out_col/row,
// flag_col/flag_row from the timer; timer_s_rst/timer_enable to the timer; hsync, vsync, video_on,
// pix_x, pix_y, frame_start, busy, frame_count, range_err to the display datapath.
module vga_timing_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pixel_clk,
  input  logic [9:0] counter_out_col,
  input  logic [9:0] counter_out_row,
  input  logic       flag_col,
  input  logic       flag_row,
  output logic       timer_s_rst,
  output logic       timer_enable,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_start,
  output logic       busy,
  output logic [7:0] frame_count,
  output logic       range_err
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  logic [1:0] r_state, w_next;
  logic       r_stop_pending;
  int         w_col, w_row;
  logic       w_pix, w_bad, w_err, w_hs, w_vs, w_vo, w_blank;
  assign w_col = int'(counter_out_col);
  assign w_row = int'(counter_out_row);
  always_comb begin
    w_next  = (r_state == IDLE)  ? (start ? CLEAR : IDLE) :
              (r_state == CLEAR) ? RUN :
              (r_state == RUN)   ? ((flag_row && (r_stop_pending || stop)) ? IDLE : RUN) : IDLE;
    w_pix   = (r_state == RUN) && pixel_clk;
    w_bad   = (w_col >= H_TOTAL) || (w_row >= V_TOTAL);
    // flag_col is redundant with the column count; any disagreement means the timer is misbehaving
    w_err   = w_bad || (flag_col != (w_col == H_TOTAL - 1));
    w_hs    = !w_bad && (w_col >= H_ACTIVE + H_FP) && (w_col < H_ACTIVE + H_FP + H_SYNC);
    w_vs    = !w_bad && (w_row >= V_ACTIVE + V_FP) && (w_row < V_ACTIVE + V_FP + V_SYNC);
    w_vo    = (w_col < H_ACTIVE) && (w_row < V_ACTIVE);
    // outputs go dark outside RUN and on the clk that leaves RUN
    w_blank = (r_state != RUN) || (w_next == IDLE);
  end
  assign timer_s_rst  = (r_state != RUN);
  assign timer_enable = (r_state == RUN);
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state        <= IDLE;
      r_stop_pending <= 1'b0;
      busy           <= 1'b0;
      hsync          <= ~SYNC_POL;
      vsync          <= ~SYNC_POL;
      video_on       <= 1'b0;
      pix_x          <= '0;
      pix_y          <= '0;
      frame_start    <= 1'b0;
      frame_count    <= '0;
      range_err      <= 1'b0;
    end else begin
      r_state     <= w_next;
      busy        <= (w_next != IDLE);
      frame_start <= w_pix && !w_blank && (w_col == 0) && (w_row == 0);
      if (r_state == CLEAR) begin
        frame_count    <= '0;
        range_err      <= 1'b0;
        r_stop_pending <= 1'b0;
      end else if (r_state == RUN) begin
        if (stop) r_stop_pending <= 1'b1;
        if (flag_row) frame_count <= frame_count + 8'd1;
        if (w_pix && w_err) range_err <= 1'b1;
      end
      if (w_blank) begin
        hsync    <= ~SYNC_POL;
        vsync    <= ~SYNC_POL;
        video_on <= 1'b0;
        pix_x    <= '0;
        pix_y    <= '0;
      end else if (w_pix) begin
        hsync    <= w_hs ? SYNC_POL : ~SYNC_POL;
        vsync    <= w_vs ? SYNC_POL : ~SYNC_POL;
        video_on <= w_vo;
        pix_x    <= w_vo ? counter_out_col : '0;
        pix_y    <= w_vo ? counter_out_row : '0;
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: randomized self-checking bench for vga_timing_ctrl against an arithmetic reference
module tb_vga_timing_ctrl;
  logic       clk = 1'b0, n_rst = 1'b0, start = 1'b0, stop = 1'b0, pixel_clk = 1'b0;
  logic       flag_col = 1'b0, flag_row = 1'b0;
  logic [9:0] counter_out_col = '0, counter_out_row = '0;
  logic       timer_s_rst, timer_enable, hsync, vsync, video_on, frame_start, busy, range_err;
  logic [9:0] pix_x, pix_y;
  logic [7:0] frame_count;
  int tests = 0, fails = 0, m_fc = 0;
  logic [23:0] exp_o;
  logic [23:0] obs;
  localparam logic [23:0] DARK = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0};

  vga_timing_ctrl dut (
    .clk(clk), .n_rst(n_rst), .start(start), .stop(stop), .pixel_clk(pixel_clk),
    .counter_out_col(counter_out_col), .counter_out_row(counter_out_row),
    .flag_col(flag_col), .flag_row(flag_row), .timer_s_rst(timer_s_rst),
    .timer_enable(timer_enable), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .busy(busy),
    .frame_count(frame_count), .range_err(range_err)
  );

  always #5 clk = ~clk;
  assign obs = {hsync, vsync, video_on, pix_x, pix_y, frame_start};

  // 640x480@60 timing from first principles: {hsync, vsync, video_on, pix_x, pix_y, frame_start}
  function automatic logic [23:0] ref_out(input int c, input int r);
    logic hs, vs, vo;
    if (c >= 800 || r >= 525) return DARK;
    hs = !(c >= 640 + 16 && c < 640 + 16 + 96);
    vs = !(r >= 480 + 10 && r < 480 + 10 + 2);
    vo = (c < 640) && (r < 480);
    return {hs, vs, vo, vo ? 10'(c) : 10'd0, vo ? 10'(r) : 10'd0, (c == 0) && (r == 0)};
  endfunction

  task automatic strobe(input int c, input int r, input logic fr, input logic st, input logic bad_fc);
    @(negedge clk);
    counter_out_col = 10'(c);
    counter_out_row = 10'(r);
    flag_col  = (c == 799) ^ bad_fc;
    flag_row  = fr;
    stop      = st;
    pixel_clk = 1'b1;
    @(posedge clk); #1;
    pixel_clk = 1'b0;
    flag_col  = 1'b0;
    flag_row  = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic idle_clk();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if ({timer_s_rst, timer_enable, busy} !== 3'b101) begin
      fails++; $display("FAIL clear_state got s_rst/en/busy=%b want 101", {timer_s_rst, timer_enable, busy});
    end
    idle_clk();
    m_fc = 0;
    tests++;
    if ({timer_s_rst, timer_enable, busy, frame_count, range_err} !== {3'b011, 8'd0, 1'b0}) begin
      fails++; $display("FAIL run_entry got s_rst/en/busy=%b fc=%0d err=%b want 011 0 0",
                        {timer_s_rst, timer_enable, busy}, frame_count, range_err);
    end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({obs, timer_s_rst, timer_enable, busy, frame_count, range_err} !== {DARK, 3'b100, 8'd0, 1'b0}) begin
      fails++; $display("FAIL reset_values got %h want %h",
                        {obs, timer_s_rst, timer_enable, busy, frame_count, range_err}, {DARK, 3'b100, 8'd0, 1'b0});
    end
    @(negedge clk);
    n_rst = 1'b1;
    strobe(100, 100, 1'b0, 1'b0, 1'b0);
    tests++;
    if ({obs, busy} !== {DARK, 1'b0}) begin
      fails++; $display("FAIL idle_hold got %h want %h", {obs, busy}, {DARK, 1'b0});
    end
  endtask

  task automatic test_first_pixel();
    do_start();
    strobe(0, 0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (obs !== ref_out(0, 0)) begin
      fails++; $display("FAIL first_pixel got %h want %h", obs, ref_out(0, 0));
    end
    idle_clk();
    tests++;
    if (frame_start !== 1'b0 || video_on !== 1'b1) begin
      fails++; $display("FAIL frame_start_pulse got fs=%b vo=%b want 0 1", frame_start, video_on);
    end
  endtask

  task automatic test_hsync_window();
    for (int c = 655; c <= 752; c++) begin
      strobe(c, 10, 1'b0, 1'b0, 1'b0);
      tests++;
      if (obs !== ref_out(c, 10)) begin
        fails++; $display("FAIL hsync_col%0d got %h want %h", c, obs, ref_out(c, 10));
      end
    end
  endtask

  task automatic test_vsync_edges();
    int cs[6] = '{0, 0, 0, 0, 639, 640};
    int rs[6] = '{489, 490, 491, 492, 479, 479};
    for (int i = 0; i < 6; i++) begin
      strobe(cs[i], rs[i], 1'b0, 1'b0, 1'b0);
      tests++;
      if (obs !== ref_out(cs[i], rs[i])) begin
        fails++; $display("FAIL edge_c%0d_r%0d got %h want %h", cs[i], rs[i], obs, ref_out(cs[i], rs[i]));
      end
    end
  endtask

  task automatic test_random();
    exp_o = obs;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle_clk();
        exp_o[0] = 1'b0;
      end else begin
        int c, r;
        logic fr;
        c  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 799));
        r  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 524));
        fr = ($urandom_range(0, 7) == 0);
        strobe(c, r, fr, 1'b0, 1'b0);
        exp_o = ref_out(c, r);
        if (fr) m_fc = (m_fc + 1) % 256;
      end
      tests++;
      if ({obs, frame_count, range_err, busy} !== {exp_o, 8'(m_fc), 1'b0, 1'b1}) begin
        fails++; $display("FAIL random_%0d got %h fc=%0d err=%b busy=%b want %h fc=%0d 0 1",
                          i, obs, frame_count, range_err, busy, exp_o, m_fc);
      end
    end
  endtask

  task automatic test_stop();
    strobe(300, 200, 1'b0, 1'b1, 1'b0);
    tests++;
    if ({obs, busy} !== {ref_out(300, 200), 1'b1}) begin
      fails++; $display("FAIL stop_request got %h busy=%b want %h 1", obs, busy, ref_out(300, 200));
    end
    strobe(700, 491, 1'b1, 1'b0, 1'b0);
    m_fc = (m_fc + 1) % 256;
    tests++;
    if ({obs, frame_count, busy, timer_s_rst, timer_enable} !== {DARK, 8'(m_fc), 3'b010}) begin
      fails++; $display("FAIL stop_at_frame got %h fc=%0d busy/s_rst/en=%b want %h fc=%0d 010",
                        obs, frame_count, {busy, timer_s_rst, timer_enable}, DARK, m_fc);
    end
    strobe(0, 0, 1'b0, 1'b0, 1'b0);
    tests++;
    if ({obs, busy} !== {DARK, 1'b0}) begin
      fails++; $display("FAIL stopped_hold got %h busy=%b want %h 0", obs, busy, DARK);
    end
  endtask

  task automatic test_back_to_back();
    do_start();
    strobe(10, 10, 1'b0, 1'b0, 1'b0);
    tests++;
    if (obs !== ref_out(10, 10)) begin
      fails++; $display("FAIL b2b_pixel got %h want %h", obs, ref_out(10, 10));
    end
    strobe(700, 491, 1'b1, 1'b1, 1'b0);
    tests++;
    if ({obs, frame_count, busy, timer_s_rst} !== {DARK, 8'd1, 2'b01}) begin
      fails++; $display("FAIL stop_with_flag got %h fc=%0d busy=%b s_rst=%b want %h 1 0 1",
                        obs, frame_count, busy, timer_s_rst, DARK);
    end
  endtask

  task automatic test_range();
    do_start();
    strobe(900, 10, 1'b0, 1'b0, 1'b0);
    tests++;
    if ({obs, range_err} !== {DARK, 1'b1}) begin
      fails++; $display("FAIL col_overrange got %h err=%b want %h 1", obs, range_err, DARK);
    end
    strobe(5, 5, 1'b0, 1'b0, 1'b0);
    tests++;
    if ({obs, range_err} !== {ref_out(5, 5), 1'b1}) begin
      fails++; $display("FAIL err_sticky got %h err=%b want %h 1", obs, range_err, ref_out(5, 5));
    end
    strobe(700, 100, 1'b1, 1'b1, 1'b0);
    tests++;
    if ({range_err, busy} !== 2'b10) begin
      fails++; $display("FAIL err_after_stop got err/busy=%b want 10", {range_err, busy});
    end
    do_start();
    strobe(799, 20, 1'b0, 1'b0, 1'b1);
    tests++;
    if (range_err !== 1'b1) begin
      fails++; $display("FAIL flag_col_mismatch got err=%b want 1", range_err);
    end
    strobe(700, 100, 1'b1, 1'b1, 1'b0);
    do_start();
    strobe(10, 600, 1'b0, 1'b0, 1'b0);
    tests++;
    if ({obs, range_err} !== {DARK, 1'b1}) begin
      fails++; $display("FAIL row_overrange got %h err=%b want %h 1", obs, range_err, DARK);
    end
    strobe(700, 100, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    do_start();
    for (int i = 1; i <= 256; i++) begin
      strobe(799, 524, 1'b1, 1'b0, 1'b0);
      m_fc = (m_fc + 1) % 256;
      if (i == 255 || i == 256) begin
        tests++;
        if ({frame_count, busy, range_err} !== {8'(m_fc), 2'b10}) begin
          fails++; $display("FAIL wrap_%0d got fc=%0d busy=%b err=%b want %0d 1 0",
                            i, frame_count, busy, range_err, m_fc);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    strobe(100, 100, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({video_on, frame_count} !== {1'b1, 8'd1}) begin
      fails++; $display("FAIL pre_reset got vo=%b fc=%0d want 1 1", video_on, frame_count);
    end
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    tests++;
    if ({obs, timer_s_rst, timer_enable, busy, frame_count, range_err} !== {DARK, 3'b100, 8'd0, 1'b0}) begin
      fails++; $display("FAIL async_reset got %h want %h",
                        {obs, timer_s_rst, timer_enable, busy, frame_count, range_err}, {DARK, 3'b100, 8'd0, 1'b0});
    end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_hsync_window();
    test_vsync_edges();
    test_random();
    test_stop();
    test_back_to_back();
    test_range();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
